// File: rtl/ddr3_pkg.sv
`default_nettype none
// ddr3_pkg: command encodings, beat address step and scheduler state encoding
// shared by the DDR3 burst scheduler and its bench.
package ddr3_pkg;

  localparam logic [2:0] CMD_WRITE      = 3'b000;
  localparam logic [2:0] CMD_READ       = 3'b001;
  localparam int         BEAT_ADDR_STEP = 8;

  typedef enum logic [2:0] {
    ST_WAIT_CAL = 3'd0,
    ST_IDLE     = 3'd1,
    ST_WR_CMD   = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_RD_CMD   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// sync_fifo: small single-clock FIFO with show-ahead head output.
// Rev 1.0
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             axi_clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr3_burst_scheduler.sv
`default_nettype none
// ddr3_burst_scheduler: splits write/read bursts into single BL8 controller
// commands, round-robin arbitrated, with credit-gated reads. Rev 1.0
module ddr3_burst_scheduler
  import ddr3_pkg::*;
#(
  parameter int ADDR_BITS  = 27,
  parameter int RD_CREDITS = 16,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                 axi_clk,
  input  logic                 rst_n,
  input  logic                 calib_i,
  input  logic                 wr_req_valid_i,
  output logic                 wr_req_ready_o,
  input  logic [ADDR_BITS-1:0] wr_req_addr_i,
  input  logic [3:0]           wr_req_len_i,
  input  logic                 s_wdata_tvalid_i,
  output logic                 s_wdata_tready_o,
  input  logic [127:0]         s_wdata_tdata_i,
  input  logic                 rd_req_valid_i,
  output logic                 rd_req_ready_o,
  input  logic [ADDR_BITS-1:0] rd_req_addr_i,
  input  logic [3:0]           rd_req_len_i,
  output logic                 m_rdata_tvalid_o,
  output logic                 m_rdata_tlast_o,
  output logic [127:0]         m_rdata_tdata_o,
  input  logic                 rd_credit_i,
  output logic [2:0]           cmd_o,
  output logic                 cmd_en_o,
  input  logic                 cmd_ready_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [127:0]         wr_data_o,
  output logic                 wr_data_en_o,
  output logic                 wr_data_end_o,
  output logic [15:0]          wr_data_mask_o,
  input  logic                 wr_data_rdy_i,
  input  logic [127:0]         rd_data_i,
  input  logic                 rd_data_valid_i,
  output logic                 busy_o
);

  localparam int CW = $clog2(RD_CREDITS + 1);
  localparam int SW = CW + 1;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [3:0]           beats_left_q, beats_left_d;
  logic                 prefer_rd_q, prefer_rd_d;
  logic [CW-1:0]        credit_q, credit_d;
  logic [SW-1:0]        credit_sum;
  logic [3:0]           ret_cnt_q, ret_cnt_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rlast_q, rlast_d;
  logic [127:0]         rdata_q, rdata_d;

  logic [7:0] rd_need, credit_ext;
  logic       rd_elig, grant_wr, grant_rd;
  logic       tag_full, tag_empty, tag_pop;
  logic [3:0] tag_head;

  assign rd_need    = {4'b0, rd_req_len_i} + 8'd1;
  assign credit_ext = 8'(credit_q);
  assign rd_elig    = rd_req_valid_i && !tag_full && (credit_ext >= rd_need);

  // prefer_rd_q points at the type that wins a tie; it starts on write.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state_q == ST_IDLE) begin
      if (wr_req_valid_i && rd_elig) begin
        grant_rd = prefer_rd_q;
        grant_wr = !prefer_rd_q;
      end else begin
        grant_wr = wr_req_valid_i;
        grant_rd = rd_elig;
      end
    end
  end

  assign wr_req_ready_o = grant_wr;
  assign rd_req_ready_o = grant_rd;
  assign busy_o         = (state_q != ST_IDLE) && (state_q != ST_WAIT_CAL);

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    beats_left_d     = beats_left_q;
    prefer_rd_d      = prefer_rd_q;
    cmd_o            = 3'b000;
    cmd_en_o         = 1'b0;
    addr_o           = '0;
    s_wdata_tready_o = 1'b0;
    wr_data_o        = '0;
    wr_data_en_o     = 1'b0;
    wr_data_end_o    = 1'b0;
    wr_data_mask_o   = '0;
    case (state_q)
      ST_WAIT_CAL: begin
        if (calib_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (grant_wr) begin
          addr_d       = wr_req_addr_i;
          beats_left_d = wr_req_len_i;
          prefer_rd_d  = 1'b1;
          state_d      = ST_WR_CMD;
        end else if (grant_rd) begin
          addr_d       = rd_req_addr_i;
          beats_left_d = rd_req_len_i;
          prefer_rd_d  = 1'b0;
          state_d      = ST_RD_CMD;
        end
      end
      ST_WR_CMD: begin
        cmd_en_o = 1'b1;
        cmd_o    = CMD_WRITE;
        addr_o   = addr_q;
        if (cmd_ready_i) state_d = ST_WR_DATA;
      end
      ST_WR_DATA: begin
        s_wdata_tready_o = wr_data_rdy_i;
        wr_data_en_o     = s_wdata_tvalid_i && wr_data_rdy_i;
        wr_data_end_o    = wr_data_en_o;
        wr_data_o        = s_wdata_tdata_i;
        if (wr_data_en_o) begin
          if (beats_left_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            addr_d       = addr_q + ADDR_BITS'(BEAT_ADDR_STEP);
            beats_left_d = beats_left_q - 4'd1;
            state_d      = ST_WR_CMD;
          end
        end
      end
      ST_RD_CMD: begin
        cmd_en_o = 1'b1;
        cmd_o    = CMD_READ;
        addr_o   = addr_q;
        if (cmd_ready_i) begin
          if (beats_left_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            addr_d       = addr_q + ADDR_BITS'(BEAT_ADDR_STEP);
            beats_left_d = beats_left_q - 4'd1;
          end
        end
      end
      default: state_d = ST_WAIT_CAL;
    endcase
  end

  // A grant never exceeds the balance, so the sum cannot underflow.
  always_comb begin
    credit_sum = {1'b0, credit_q} + SW'(rd_credit_i)
                 - (grant_rd ? SW'(rd_need) : SW'(0));
    if (credit_sum > SW'(RD_CREDITS)) credit_d = CW'(RD_CREDITS);
    else                              credit_d = credit_sum[CW-1:0];
  end

  always_comb begin
    rvalid_d  = rd_data_valid_i && !tag_empty;
    rdata_d   = rvalid_d ? rd_data_i : '0;
    rlast_d   = rvalid_d && (ret_cnt_q == tag_head);
    tag_pop   = rlast_d;
    ret_cnt_d = ret_cnt_q;
    if (rvalid_d) ret_cnt_d = rlast_d ? 4'd0 : ret_cnt_q + 4'd1;
  end

  assign m_rdata_tvalid_o = rvalid_q;
  assign m_rdata_tlast_o  = rlast_q;
  assign m_rdata_tdata_o  = rdata_q;

  sync_fifo #(
    .WIDTH (4),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .axi_clk     (axi_clk),
    .rst_n       (rst_n),
    .push_i      (grant_rd),
    .push_data_i (rd_req_len_i),
    .pop_i       (tag_pop),
    .head_o      (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty)
  );

  always_ff @(posedge axi_clk) begin
    if (!rst_n) begin
      state_q      <= ST_WAIT_CAL;
      addr_q       <= '0;
      beats_left_q <= '0;
      prefer_rd_q  <= 1'b0;
      credit_q     <= CW'(RD_CREDITS);
      ret_cnt_q    <= '0;
      rvalid_q     <= 1'b0;
      rlast_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      prefer_rd_q  <= prefer_rd_d;
      credit_q     <= credit_d;
      ret_cnt_q    <= ret_cnt_d;
      rvalid_q     <= rvalid_d;
      rlast_q      <= rlast_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule
`default_nettype wire
